sca_txn_sequencer: RTL and testbench
====================================

# sca_txn_sequencer

Bus-master sequencer that drives the 16-bit register port of the HDLC link manager on behalf of one requester. It converts a single SCA command (channel, command, 32-bit data) into the ordered TX register writes and send strobe, then polls for the reply. It reads back the error and data words, acknowledges the reply, and returns a one-cycle response. A programmable timeout resets the link and reports failure when no reply arrives.

## Interface
- ADDR_TX_CHCMD, default 4'h0: TX word {channel, command}
- ADDR_TX_DLO, default 4'h1: TX data[15:0]
- ADDR_TX_DHI, default 4'h2: TX data[31:16]
- ADDR_TX_CTRL, default 4'h7: control; bit0 = send, bit5 = link reset
- ADDR_RX_STAT, default 4'h8: bit0 = reply available; writing bit0 = 1 pops the reply
- ADDR_RX_ERR, default 4'h9: reply error byte in [7:0]
- ADDR_RX_DLO, default 4'hA; ADDR_RX_DHI, default 4'hB: reply data halves
- TIMEOUT_CYCLES, default 4096: poll budget in io_clk cycles, ≥ 2

Ports:
- io_clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high
- req_valid  in  1  command request
- req_ready  out  1  high only in IDLE
- req_channel  in  8;  req_command  in  8;  req_data  in  32
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_data  out  32;  rsp_error  out  8;  rsp_timeout  out  1
- busy  out  1  high in any state other than IDLE
- timeout_count  out  16  saturating count of timeouts
- io_addr  out  4;  io_din  out  16;  io_we  out  1  bus to the link manager
- io_dout  in  16  combinational read data for the current io_addr

## Operation
- Accept: when req_valid && req_ready, capture channel, command and data, then leave IDLE.
- Write phase: one io_we cycle per state.
  - WR_CHCMD: {ch, cmd}
  - WR_DLO: data[15:0]
  - WR_DHI: data[31:16]
  - WR_SEND: ADDR_TX_CTRL, 16'h0001
- Timeout counter clears in WR_SEND and increments every POLL cycle.
- Reads take two cycles each: the ADDR state drives io_addr with io_we = 0; the SAMPLE state holds io_addr and registers io_dout.
- POLL: read ADDR_RX_STAT.
  - bit0 = 1: go to RD_ERR.
  - Otherwise re-poll at once.
  - Counter reaching TIMEOUT_CYCLES: go to TO_RESET. Timeout takes priority if both occur in the same sample.
- RD_ERR stores [7:0]; RD_DLO and RD_DHI assemble rsp_data.
- ACK: write ADDR_RX_STAT with 16'h0001, then RESP.
- RESP: rsp_valid = 1 for one cycle with rsp_timeout = 0, then IDLE.
- TO_RESET: write ADDR_TX_CTRL with 16'h0020, then RESP with rsp_timeout = 1, rsp_error = 8'hFF, rsp_data = 0. timeout_count increments and saturates at 16'hFFFF.
- When io_we = 0, io_din = 0. io_addr = 0 in IDLE.
- rsp_data, rsp_error and rsp_timeout hold their values until the next rsp_valid.

## Timing
- Reset values: req_ready = 0 while reset is high and 1 the first cycle after; busy = 0, rsp_valid = 0, rsp_data = 0, rsp_error = 0, rsp_timeout = 0, timeout_count = 0, io_addr = 0, io_din = 0, io_we = 0.
- Reset mid-transaction: abort on the next edge, return to IDLE, emit no response and no further bus writes. The link manager itself is not reset.
- Best-case timeline, with acceptance at cycle 0:
  - Writes at cycles 1–4.
  - Poll at cycles 5–6.
  - Error read at 7–8, DLO at 9–10, DHI at 11–12.
  - ACK at 13; rsp_valid at 14.
  - req_ready returns at cycle 15.
- Each extra failed poll adds 2 cycles.
- Timeout path: TO_RESET is one cycle, followed by RESP.
- req_valid during busy is ignored; the request is not queued.
- Back-to-back: the earliest next acceptance is the cycle after RESP.

## Test plan
- Reply ready on the first poll, with io_dout model err = 8'h00 and data = 32'h12345678 → bus writes 0x0102, 0x5678 and 0x1234 for ch = 1, cmd = 2, data = 32'h12345678; send 0x0001 at addr 7; ACK; rsp_valid at cycle 14 with rsp_data = 32'h12345678 and rsp_error = 0.
- Status held 0 for 3 polls, then 1 → rsp_valid at cycle 20; exactly one ACK write.
- Status never set, TIMEOUT_CYCLES = 16 → write of 0x0020 to addr 7; rsp_timeout = 1, rsp_error = 8'hFF, rsp_data = 0; timeout_count = 1.
- Reset asserted during RD_DLO → no rsp_valid and no ACK write; req_ready = 1 the cycle after reset deasserts.
- req_valid held high continuously → requests accepted exactly 15 cycles apart; a request changed while busy is not captured.
- Force 65536 timeouts (preload via short TIMEOUT_CYCLES = 2) → timeout_count saturates at 16'hFFFF.

Source files
------------

// File: rtl/sca_txn_sequencer.sv
// Bus-master sequencer: turns one SCA command into link-manager TX register
// writes, polls for the reply, reads it back, acknowledges it, and responds.
module sca_txn_sequencer #(
  parameter logic [3:0]  ADDR_TX_CHCMD  = 4'h0,
  parameter logic [3:0]  ADDR_TX_DLO    = 4'h1,
  parameter logic [3:0]  ADDR_TX_DHI    = 4'h2,
  parameter logic [3:0]  ADDR_TX_CTRL   = 4'h7,
  parameter logic [3:0]  ADDR_RX_STAT   = 4'h8,
  parameter logic [3:0]  ADDR_RX_ERR    = 4'h9,
  parameter logic [3:0]  ADDR_RX_DLO    = 4'hA,
  parameter logic [3:0]  ADDR_RX_DHI    = 4'hB,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        io_clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_channel,
  input  logic [7:0]  req_command,
  input  logic [31:0] req_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [7:0]  rsp_error,
  output logic        rsp_timeout,
  output logic        busy,
  output logic [15:0] timeout_count,
  output logic [3:0]  io_addr,
  output logic [15:0] io_din,
  output logic        io_we,
  input  logic [15:0] io_dout
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_CHCMD, S_WR_DLO, S_WR_DHI, S_WR_SEND,
    S_POLL_A, S_POLL_S, S_ERR_A, S_ERR_S, S_DLO_A, S_DLO_S,
    S_DHI_A, S_DHI_S, S_ACK, S_TO_RESET, S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [15:0]      tcount_q, tcount_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic [7:0]       rsp_error_q, rsp_error_d;
  logic             rsp_to_q, rsp_to_d;
  logic [7:0]       ch_q, cmd_q, err_q;
  logic [31:0]      data_q;
  logic [15:0]      dlo_q, dhi_q;
  logic             poll_to;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge io_clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pcnt_q      <= '0;
      tcount_q    <= '0;
      rsp_data_q  <= '0;
      rsp_error_q <= '0;
      rsp_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      tcount_q    <= tcount_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
      rsp_to_q    <= rsp_to_d;
    end
  end

  // Request capture and reply staging; contents only matter once qualified by state.
  always_ff @(posedge io_clk) begin
    if (req_valid && req_ready) begin
      ch_q   <= req_channel;
      cmd_q  <= req_command;
      data_q <= req_data;
    end
    if (state_q == S_ERR_S) err_q <= io_dout[7:0];
    if (state_q == S_DLO_S) dlo_q <= io_dout;
    if (state_q == S_DHI_S) dhi_q <= io_dout;
  end

  // Budget is spent once the count including this sample reaches TIMEOUT_CYCLES.
  assign poll_to = (pcnt_q >= TO_LAST);

  always_comb begin
    state_d     = state_q;
    pcnt_d      = pcnt_q;
    tcount_d    = tcount_q;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    rsp_to_d    = rsp_to_q;
    io_addr     = 4'h0;
    io_din      = 16'h0000;
    io_we       = 1'b0;
    case (state_q)
      S_IDLE:     if (req_valid) state_d = S_WR_CHCMD;
      S_WR_CHCMD: begin
        io_addr = ADDR_TX_CHCMD; io_din = {ch_q, cmd_q}; io_we = 1'b1;
        state_d = S_WR_DLO;
      end
      S_WR_DLO: begin
        io_addr = ADDR_TX_DLO; io_din = data_q[15:0]; io_we = 1'b1;
        state_d = S_WR_DHI;
      end
      S_WR_DHI: begin
        io_addr = ADDR_TX_DHI; io_din = data_q[31:16]; io_we = 1'b1;
        state_d = S_WR_SEND;
      end
      S_WR_SEND: begin
        io_addr = ADDR_TX_CTRL; io_din = 16'h0001; io_we = 1'b1;
        pcnt_d  = '0;
        state_d = S_POLL_A;
      end
      S_POLL_A: begin
        io_addr = ADDR_RX_STAT;
        pcnt_d  = pcnt_q + 1'b1;
        state_d = S_POLL_S;
      end
      S_POLL_S: begin
        io_addr = ADDR_RX_STAT;
        pcnt_d  = pcnt_q + 1'b1;
        if (poll_to)         state_d = S_TO_RESET;
        else if (io_dout[0]) state_d = S_ERR_A;
        else                 state_d = S_POLL_A;
      end
      S_ERR_A: begin io_addr = ADDR_RX_ERR; state_d = S_ERR_S; end
      S_ERR_S: begin io_addr = ADDR_RX_ERR; state_d = S_DLO_A; end
      S_DLO_A: begin io_addr = ADDR_RX_DLO; state_d = S_DLO_S; end
      S_DLO_S: begin io_addr = ADDR_RX_DLO; state_d = S_DHI_A; end
      S_DHI_A: begin io_addr = ADDR_RX_DHI; state_d = S_DHI_S; end
      S_DHI_S: begin io_addr = ADDR_RX_DHI; state_d = S_ACK; end
      S_ACK: begin
        io_addr     = ADDR_RX_STAT; io_din = 16'h0001; io_we = 1'b1;
        rsp_data_d  = {dhi_q, dlo_q};
        rsp_error_d = err_q;
        rsp_to_d    = 1'b0;
        state_d     = S_RESP;
      end
      S_TO_RESET: begin
        io_addr     = ADDR_TX_CTRL; io_din = 16'h0020; io_we = 1'b1;
        rsp_data_d  = 32'h0;
        rsp_error_d = 8'hFF;
        rsp_to_d    = 1'b1;
        tcount_d    = sat_inc16(tcount_q);
        state_d     = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // An aborting reset must not let a write escape in its own cycle.
    if (reset) begin
      io_we  = 1'b0;
      io_din = 16'h0000;
    end
  end

  assign req_ready     = (state_q == S_IDLE) && !reset;
  assign busy          = (state_q != S_IDLE);
  assign rsp_valid     = (state_q == S_RESP);
  assign rsp_data      = rsp_data_q;
  assign rsp_error     = rsp_error_q;
  assign rsp_timeout   = rsp_to_q;
  assign timeout_count = tcount_q;

endmodule

// File: tb/tb_sca_txn_sequencer.sv
// Bench for sca_txn_sequencer: link-manager register model plus a transaction-level reference.
module tb_sca_txn_sequencer;
  localparam int T   = 16;
  localparam int NTO = (T + 1) / 2;   // poll index at which the budget is spent

  logic        io_clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_channel = 8'h0, req_command = 8'h0;
  logic [31:0] req_data = 32'h0;
  logic        rsp_valid, rsp_timeout, busy, io_we;
  logic [31:0] rsp_data;
  logic [7:0]  rsp_error;
  logic [15:0] timeout_count, io_din, io_dout;
  logic [3:0]  io_addr;

  sca_txn_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .io_clk(io_clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_channel(req_channel), .req_command(req_command), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .rsp_timeout(rsp_timeout), .busy(busy), .timeout_count(timeout_count),
    .io_addr(io_addr), .io_din(io_din), .io_we(io_we), .io_dout(io_dout)
  );

  always #5 io_clk = ~io_clk;

  int tests = 0, failed = 0;
  int cyc = 0, rd8 = 0, rsp_cnt = 0, din_bad = 0;
  int k_cur = 0;
  int tcount_m = 0;
  logic [7:0]  err_cur = 8'h0;
  logic [31:0] rd_cur = 32'h0;
  logic [3:0]  wa[$];
  logic [15:0] wd[$];
  int          wc[$];

  // Link manager: reply becomes available on the (k_cur+1)-th status poll.
  always_comb begin
    case (io_addr)
      4'h8:    io_dout = {15'd0, 1'((rd8 / 2) >= k_cur)};
      4'h9:    io_dout = {8'hA5, err_cur};
      4'hA:    io_dout = rd_cur[15:0];
      4'hB:    io_dout = rd_cur[31:16];
      default: io_dout = 16'hDEAD;
    endcase
  end

  always @(posedge io_clk) begin
    if (io_we) begin
      wa.push_back(io_addr); wd.push_back(io_din); wc.push_back(cyc);
    end
    if (!io_we && io_din != 16'h0) din_bad++;
    if (rsp_valid) rsp_cnt++;
    if (req_valid && req_ready) rd8 = 0;
    else if (io_addr == 4'h8 && !io_we) rd8++;
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic [7:0] ch, input logic [7:0] cmd, input logic [31:0] d,
                         input int k, input logic [7:0] e, input logic [31:0] rd);
    int t0, tr, lat;
    bit to;
    logic [3:0]  ea[5];
    logic [15:0] ed[5];
    @(negedge io_clk);
    k_cur = k; err_cur = e; rd_cur = rd;
    req_channel = ch; req_command = cmd; req_data = d; req_valid = 1'b1;
    wa.delete(); wd.delete(); wc.delete();
    chk("accept_ready", 32'(req_ready), 32'd1);
    t0 = cyc;
    @(negedge io_clk);
    req_valid = 1'b0; req_data = $urandom; req_channel = 8'($urandom);
    to  = (k + 1 >= NTO);
    lat = to ? (2 * NTO + 6) : (14 + 2 * k);
    tr  = -1;
    for (int i = 1; i < 80; i++) begin
      if (rsp_valid) begin tr = cyc - t0; break; end
      @(negedge io_clk);
    end
    chk("rsp_latency", 32'(tr), 32'(lat));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(to));
    chk("rsp_error", 32'(rsp_error), to ? 32'hFF : 32'(e));
    chk("rsp_data", rsp_data, to ? 32'h0 : rd);
    if (to) tcount_m = (tcount_m + 1 > 65535) ? 65535 : tcount_m + 1;
    @(negedge io_clk);
    chk("rsp_pulse_one", 32'(rsp_valid), 32'd0);
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("rsp_data_hold", rsp_data, to ? 32'h0 : rd);
    chk("timeout_count", 32'(timeout_count), 32'(tcount_m));
    ea = '{4'h0, 4'h1, 4'h2, 4'h7, to ? 4'h7 : 4'h8};
    ed = '{{ch, cmd}, d[15:0], d[31:16], 16'h0001, to ? 16'h0020 : 16'h0001};
    chk("n_writes", 32'(wa.size()), 32'd5);
    for (int i = 0; i < 5 && i < wa.size(); i++) begin
      chk($sformatf("wr%0d_addr", i), 32'(wa[i]), 32'(ea[i]));
      chk($sformatf("wr%0d_data", i), 32'(wd[i]), 32'(ed[i]));
      chk($sformatf("wr%0d_cycle", i), 32'(wc[i] - t0), (i < 4) ? 32'(i + 1) : 32'(lat - 1));
    end
  endtask

  initial begin
    int t0, rc;
    int acc[$];
    logic [31:0] vals[3];

    // Reset state
    repeat (2) @(negedge io_clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("rst_tcount", 32'(timeout_count), 32'd0);
    chk("rst_io", {11'd0, io_addr, io_we, io_din}, 32'd0);
    reset = 1'b0;
    #1 chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Directed: first-poll reply, delayed reply, timeout, timeout-vs-reply priority
    run_txn(8'h01, 8'h02, 32'h12345678, 0, 8'h00, 32'h12345678);
    run_txn(8'h33, 8'h44, 32'hCAFEF00D, 3, 8'h5A, 32'h0BADBEEF);
    run_txn(8'h07, 8'h08, 32'hFFFF0000, 100, 8'h11, 32'h22223333);
    run_txn(8'hAB, 8'hCD, 32'h0000FFFF, NTO - 1, 8'h00, 32'h44445555);
    run_txn(8'hEE, 8'h10, 32'h80000001, NTO - 2, 8'hC3, 32'h66667777);

    // Randomized transactions
    for (int i = 0; i < 8; i++)
      run_txn(8'($urandom), 8'($urandom), $urandom, int'($urandom_range(0, NTO + 1)),
              8'($urandom), $urandom);

    // Reset during the DLO read: abort, no ACK, no response
    @(negedge io_clk);
    k_cur = 0; req_valid = 1'b1; req_data = 32'h01020304;
    wa.delete(); wd.delete(); wc.delete();
    t0 = cyc;
    @(negedge io_clk); req_valid = 1'b0;
    while (cyc < t0 + 9) @(negedge io_clk);
    rc = rsp_cnt;
    reset = 1'b1;
    #1 chk("midrst_ready_low", 32'(req_ready), 32'd0);
    @(negedge io_clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_io", {11'd0, io_addr, io_we, io_din}, 32'd0);
    chk("midrst_rsp_data", rsp_data, 32'd0);
    chk("midrst_tcount", 32'(timeout_count), 32'd0);
    tcount_m = 0;
    reset = 1'b0;
    #1 chk("midrst_ready_after", 32'(req_ready), 32'd1);
    repeat (20) @(negedge io_clk);
    chk("midrst_no_rsp", 32'(rsp_cnt - rc), 32'd0);
    chk("midrst_writes", 32'(wa.size()), 32'd4);

    // Back-to-back with req_valid held high
    vals = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4};
    wa.delete(); wd.delete(); wc.delete();
    rc = rsp_cnt;
    @(negedge io_clk);
    req_valid = 1'b1;
    for (int i = 0; i < 60 && acc.size() < 3; i++) begin
      if (req_ready) begin
        req_data = vals[acc.size()];
        acc.push_back(cyc);
      end else req_data = $urandom;
      @(negedge io_clk);
    end
    req_valid = 1'b0;
    repeat (16) @(negedge io_clk);
    chk("b2b_accepts", 32'(acc.size()), 32'd3);
    if (acc.size() == 3) begin
      chk("b2b_gap1", 32'(acc[1] - acc[0]), 32'd15);
      chk("b2b_gap2", 32'(acc[2] - acc[1]), 32'd15);
    end
    chk("b2b_rsps", 32'(rsp_cnt - rc), 32'd3);
    begin
      int n = 0;
      for (int i = 0; i < wa.size(); i++)
        if (wa[i] == 4'h2 && n < 3) begin
          chk($sformatf("b2b_dhi%0d", n), 32'(wd[i]), 32'(vals[n][31:16]));
          chk($sformatf("b2b_dlo%0d", n), 32'(wd[i-1]), 32'(vals[n][15:0]));
          n++;
        end
      chk("b2b_dhi_count", 32'(n), 32'd3);
    end

    // Saturation: preload near the top, then two more timeouts
    @(negedge io_clk);
    force dut.tcount_q = 16'hFFFE;
    @(negedge io_clk);
    release dut.tcount_q;
    tcount_m = 65534;
    @(negedge io_clk);
    chk("preload", 32'(timeout_count), 32'hFFFE);
    run_txn(8'h01, 8'h01, 32'h1, 100, 8'h0, 32'h0);
    run_txn(8'h02, 8'h02, 32'h2, 100, 8'h0, 32'h0);
    chk("tcount_sat", 32'(timeout_count), 32'hFFFF);

    chk("din_zero_when_idle", 32'(din_bad), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
